// File: rtl/dsp_pkg.sv
// Shared OPMODE encodings, datapath widths and the partial-product sign-extension helper
// for the DSP slice post-multiplier stage.
package dsp_pkg;

  localparam int PP_W = 43;
  localparam int P_W  = 48;
  localparam int S_W  = P_W + 1;

  typedef enum logic [1:0] {
    OP_PROD = 2'b00,
    OP_ACC  = 2'b01,
    OP_CADD = 2'b10,
    OP_HOLD = 2'b11
  } opmode_e;

  function automatic logic [P_W-1:0] sext_pp(input logic [PP_W-1:0] v);
    return {{(P_W-PP_W){v[PP_W-1]}}, v};
  endfunction

endpackage

// File: rtl/pp_accumulate_alu_if.sv
// Operand/result bundle between the multiplier stage driver (master) and the accumulate ALU (slave).
interface pp_accumulate_alu_if;
  import dsp_pkg::*;

  // There is no valid/ready pair: every rising CLK edge with CEP=1 is one
  // accepted update, and P/flags are always valid (registered or combinational).
  logic              CEP;
  logic [PP_W-1:0]   PP1;
  logic [PP_W-1:0]   PP2;
  logic [P_W-1:0]    C;
  logic [1:0]        OPMODE;
  logic              CARRYIN;
  logic [P_W-1:0]    P;
  logic              OVERFLOW;
  logic              UNDERFLOW;
  logic              ACC_DONE;
  logic [15:0]       dbg_count;
  logic              dbg_restart;

  modport master (
    output CEP, PP1, PP2, C, OPMODE, CARRYIN,
    input  P, OVERFLOW, UNDERFLOW, ACC_DONE, dbg_count, dbg_restart
  );

  modport slave (
    input  CEP, PP1, PP2, C, OPMODE, CARRYIN,
    output P, OVERFLOW, UNDERFLOW, ACC_DONE, dbg_count, dbg_restart
  );

endinterface

// File: rtl/pp_combine.sv
// Sign-extends the two partial products to the P width and sums them into the full product;
// the product term is forced to zero when the multiplier is configured out.
module pp_combine
  import dsp_pkg::*;
#(
  parameter string USE_MULT = "multiply"
) (
  input  logic [PP_W-1:0] pp1,
  input  logic [PP_W-1:0] pp2,
  output logic [P_W-1:0]  prod
);

  localparam bit MULT_ON = (USE_MULT != "none");

  always_comb begin
    prod = '0;
    if (MULT_ON) begin
      prod = sext_pp(pp1) + sext_pp(pp2);
    end
  end

endmodule

// File: rtl/pp_accumulate_alu.sv
// Post-multiplier accumulate ALU: combines the product with feedback or C, flags signed
// overflow/underflow and runs an optional fixed-length accumulation counter with auto-restart.
module pp_accumulate_alu
  import dsp_pkg::*;
#(
  parameter int    PREG     = 1,
  parameter string USE_MULT = "multiply",
  parameter int    ACC_LEN  = 0
) (
  input  logic                CLK,
  input  logic                RSTP,
  pp_accumulate_alu_if.slave  bus
);

  localparam bit CNT_ON = (ACC_LEN > 0);
  localparam int CNT_W  = CNT_ON ? $clog2(ACC_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  opmode_e          op;
  logic [P_W-1:0]   prod;
  logic [P_W-1:0]   fb;
  logic [P_W-1:0]   addend;
  logic [S_W-1:0]   sum;
  logic [P_W-1:0]   next_val;
  logic             ovf_n;
  logic             unf_n;

  logic [P_W-1:0]   acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             done_q, done_d;
  logic             restart_q, restart_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op = opmode_e'(bus.OPMODE);

  pp_combine #(
    .USE_MULT (USE_MULT)
  ) u_pp_combine (
    .pp1  (bus.PP1),
    .pp2  (bus.PP2),
    .prod (prod)
  );

  // One guard bit above P: the top two sum bits disagreeing means the P-wide result wrapped.
  always_comb begin
    fb       = (CNT_ON && restart_q) ? '0 : acc_q;
    addend   = '0;
    sum      = '0;
    next_val = acc_q;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    case (op)
      OP_ACC:  addend = fb;
      OP_CADD: addend = bus.C;
      default: addend = '0;
    endcase
    sum = {addend[P_W-1], addend} + {prod[P_W-1], prod} + S_W'(bus.CARRYIN);
    if (op != OP_HOLD) begin
      next_val = sum[P_W-1:0];
      ovf_n    = ~sum[P_W] &  sum[P_W-1];
      unf_n    =  sum[P_W] & ~sum[P_W-1];
    end
  end

  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    cnt_d     = cnt_q;
    restart_d = restart_q;
    done_d    = 1'b0;
    if (bus.CEP) begin
      acc_d = next_val;
      ovf_d = ovf_n;
      unf_d = unf_n;
      if (CNT_ON) begin
        case (op)
          OP_ACC: begin
            restart_d = 1'b0;
            if (cnt_q == CNT_LAST) begin
              cnt_d     = '0;
              restart_d = 1'b1;
              done_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          OP_PROD, OP_CADD: begin
            cnt_d     = '0;
            restart_d = 1'b0;
          end
          default: begin
            cnt_d     = cnt_q;
            restart_d = restart_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RSTP) begin
    if (RSTP) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      done_q    <= done_d;
      restart_q <= restart_d;
      cnt_q     <= cnt_d;
    end
  end

  // Unregistered outputs are still forced low while reset is held.
  always_comb begin
    if (PREG != 0) begin
      bus.P         = acc_q;
      bus.OVERFLOW  = ovf_q;
      bus.UNDERFLOW = unf_q;
    end else begin
      bus.P         = RSTP ? '0 : next_val;
      bus.OVERFLOW  = RSTP ? 1'b0 : ovf_n;
      bus.UNDERFLOW = RSTP ? 1'b0 : unf_n;
    end
    bus.ACC_DONE    = done_q;
    bus.dbg_count   = 16'(cnt_q);
    bus.dbg_restart = restart_q;
  end

endmodule

// File: tb/tb_pp_accumulate_alu.sv
// Self-checking bench: three configurations driven in lockstep and compared with an
// arithmetic reference model of the accumulate ALU.
module tb_pp_accumulate_alu;
  import dsp_pkg::*;

  localparam longint MAXP = 64'sd140737488355327;
  localparam longint MINP = -64'sd140737488355328;

  typedef struct {
    longint acc;
    bit     ovf;
    bit     unf;
    bit     done;
    bit     restart;
    int     cnt;
  } model_t;

  logic            clk;
  logic            rst;
  logic            cep;
  logic [42:0]     pp1;
  logic [42:0]     pp2;
  logic [47:0]     c;
  logic [1:0]      opmode;
  logic            cin;

  int total = 0;
  int bad   = 0;

  model_t m [3];
  bit     cfg_preg [3] = '{1'b1, 1'b0, 1'b1};
  bit     cfg_mult [3] = '{1'b1, 1'b1, 1'b0};
  int     cfg_len  [3] = '{4, 4, 0};

  logic [47:0] p_o   [3];
  logic        ovf_o [3];
  logic        unf_o [3];
  logic        done_o[3];

  pp_accumulate_alu_if ifa ();
  pp_accumulate_alu_if ifb ();
  pp_accumulate_alu_if ifc ();

  assign ifa.CEP = cep;  assign ifa.PP1 = pp1;  assign ifa.PP2 = pp2;
  assign ifa.C = c;      assign ifa.OPMODE = opmode;  assign ifa.CARRYIN = cin;
  assign ifb.CEP = cep;  assign ifb.PP1 = pp1;  assign ifb.PP2 = pp2;
  assign ifb.C = c;      assign ifb.OPMODE = opmode;  assign ifb.CARRYIN = cin;
  assign ifc.CEP = cep;  assign ifc.PP1 = pp1;  assign ifc.PP2 = pp2;
  assign ifc.C = c;      assign ifc.OPMODE = opmode;  assign ifc.CARRYIN = cin;

  assign p_o[0] = ifa.P;  assign ovf_o[0] = ifa.OVERFLOW;  assign unf_o[0] = ifa.UNDERFLOW;  assign done_o[0] = ifa.ACC_DONE;
  assign p_o[1] = ifb.P;  assign ovf_o[1] = ifb.OVERFLOW;  assign unf_o[1] = ifb.UNDERFLOW;  assign done_o[1] = ifb.ACC_DONE;
  assign p_o[2] = ifc.P;  assign ovf_o[2] = ifc.OVERFLOW;  assign unf_o[2] = ifc.UNDERFLOW;  assign done_o[2] = ifc.ACC_DONE;

  pp_accumulate_alu #(.PREG(1), .USE_MULT("multiply"), .ACC_LEN(4)) dut_reg (
    .CLK (clk), .RSTP (rst), .bus (ifa.slave)
  );
  pp_accumulate_alu #(.PREG(0), .USE_MULT("multiply"), .ACC_LEN(4)) dut_comb (
    .CLK (clk), .RSTP (rst), .bus (ifb.slave)
  );
  pp_accumulate_alu #(.PREG(1), .USE_MULT("none"), .ACC_LEN(0)) dut_nomult (
    .CLK (clk), .RSTP (rst), .bus (ifc.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx43(input logic [42:0] v);
    logic signed [42:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic longint sx48(input logic [47:0] v);
    logic signed [47:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic void model_eval(input int k, output logic [47:0] nxt, output bit o, output bit u);
    longint s, pr, fb;
    pr = cfg_mult[k] ? (sx43(pp1) + sx43(pp2)) : 64'sd0;
    fb = m[k].restart ? 64'sd0 : m[k].acc;
    s  = m[k].acc;
    case (opmode)
      2'b00:   s = pr + longint'(cin);
      2'b01:   s = fb + pr + longint'(cin);
      2'b10:   s = sx48(c) + pr + longint'(cin);
      default: s = m[k].acc;
    endcase
    nxt = s[47:0];
    o   = (opmode != 2'b11) && (s > MAXP);
    u   = (opmode != 2'b11) && (s < MINP);
  endfunction

  function automatic void model_commit(input int k, input logic [47:0] nxt, input bit o, input bit u);
    m[k].done = 1'b0;
    if (!cep) return;
    m[k].acc = sx48(nxt);
    m[k].ovf = o;
    m[k].unf = u;
    if (cfg_len[k] > 0) begin
      if (opmode == 2'b01) begin
        m[k].restart = 1'b0;
        m[k].cnt++;
        if (m[k].cnt == cfg_len[k]) begin
          m[k].cnt     = 0;
          m[k].restart = 1'b1;
          m[k].done    = 1'b1;
        end
      end else if (opmode != 2'b11) begin
        m[k].cnt     = 0;
        m[k].restart = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m[k].acc = 0; m[k].ovf = 0; m[k].unf = 0;
      m[k].done = 0; m[k].restart = 0; m[k].cnt = 0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Compare all three DUTs mid-cycle, then let one rising edge happen and update the model.
  task automatic step();
    logic [47:0] nx [3];
    bit          o  [3];
    bit          u  [3];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      model_eval(k, nx[k], o[k], u[k]);
      if (cfg_preg[k]) begin
        chk($sformatf("p%0d", k),   p_o[k],          m[k].acc[47:0]);
        chk($sformatf("ovf%0d", k), 48'(ovf_o[k]),   48'(m[k].ovf));
        chk($sformatf("unf%0d", k), 48'(unf_o[k]),   48'(m[k].unf));
      end else begin
        chk($sformatf("p%0d", k),   p_o[k],          nx[k]);
        chk($sformatf("ovf%0d", k), 48'(ovf_o[k]),   48'(o[k]));
        chk($sformatf("unf%0d", k), 48'(unf_o[k]),   48'(u[k]));
      end
      chk($sformatf("done%0d", k), 48'(done_o[k]), 48'(m[k].done));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_commit(k, nx[k], o[k], u[k]);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_p"},    p_o[k],          48'd0);
      chk({tag, "_ovf"},  48'(ovf_o[k]),   48'd0);
      chk({tag, "_unf"},  48'(unf_o[k]),   48'd0);
      chk({tag, "_done"}, 48'(done_o[k]),  48'd0);
    end
    rst = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input longint a, input longint b,
                       input logic [47:0] cv, input logic ci, input logic ce);
    opmode = op;
    pp1    = a[42:0];
    pp2    = b[42:0];
    c      = cv;
    cin    = ci;
    cep    = ce;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] r;
    logic [47:0] acc_exp [5];
    acc_exp = '{48'd5, 48'd10, 48'd15, 48'd20, 48'd5};

    rst = 1'b1;
    drive(2'b00, 0, 0, 48'd0, 1'b0, 1'b0);
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) chk("reset_p", p_o[k], 48'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // plain product 100 + (-30)
    drive(2'b00, 100, -30, 48'd0, 1'b0, 1'b1);
    #1 chk("tp_p70_comb", p_o[1], 48'd70);
    step();
    chk("tp_p70_reg", p_o[0], 48'd70);
    chk("tp_p70_ovf", 48'(ovf_o[0]), 48'd0);

    // C-add overflow then underflow
    drive(2'b10, 1, 0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1);
    step();
    chk("tp_ovf_p", p_o[0], 48'h8000_0000_0000);
    chk("tp_ovf_flag", 48'(ovf_o[0]), 48'd1);
    drive(2'b10, -1, 0, 48'h8000_0000_0000, 1'b0, 1'b1);
    step();
    chk("tp_unf_p", p_o[0], 48'h7FFF_FFFF_FFFF);
    chk("tp_unf_flag", 48'(unf_o[0]), 48'd1);

    // accumulation run of length 4 with auto-restart
    pulse_reset("rst_a");
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 3, 2, 48'd0, 1'b0, 1'b1);
      step();
      chk("tp_acc_p", p_o[0], acc_exp[i]);
      chk("tp_acc_done", 48'(done_o[0]), 48'(i == 3));
    end

    // carry-in on the first update of a fresh run
    pulse_reset("rst_b");
    drive(2'b01, 3, 2, 48'd0, 1'b1, 1'b1);
    step();
    chk("tp_cin_p", p_o[0], 48'd6);

    // clock-enable hold, then OPMODE hold
    pulse_reset("rst_c");
    repeat (2) begin
      drive(2'b01, 3, 2, 48'd0, 1'b0, 1'b1);
      step();
    end
    repeat (3) begin
      drive(2'b01, 3, 2, 48'd0, 1'b0, 1'b0);
      step();
      chk("tp_cep_hold", p_o[0], 48'd10);
      chk("tp_cep_done", 48'(done_o[0]), 48'd0);
    end
    drive(2'b11, 3, 2, 48'd0, 1'b0, 1'b1);
    step();
    chk("tp_hold_p", p_o[0], 48'd10);
    chk("tp_hold_ovf", 48'(ovf_o[0]), 48'd0);

    // reset mid-run, then a full run of 4
    pulse_reset("rst_d");
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 3, 2, 48'd0, 1'b0, 1'b1);
      step();
      chk("tp_rerun_done", 48'(done_o[0]), 48'(i == 3));
    end

    // multiplier configured out
    drive(2'b10, 999, 999, 48'd1234, 1'b0, 1'b1);
    step();
    chk("tp_nomult", p_o[2], 48'd1234);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) pp1 = r[42:0];
      else pp1 = 43'(longint'($urandom_range(0, 400)) - 200);
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) pp2 = r[42:0];
      else pp2 = 43'(longint'($urandom_range(0, 400)) - 200);
      r = {$urandom(), $urandom()};
      c      = r[47:0];
      opmode = ($urandom_range(0, 3) < 2) ? 2'b01 : 2'($urandom_range(0, 3));
      cin    = 1'($urandom_range(0, 1));
      cep    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pp_accumulate_alu.md
Name: pp_accumulate_alu

Overview:
Consumer end of the signed multiplier's partial-product interface. Takes the two 43-bit signed partial products PP1/PP2 (their sum is the full A*B product) and sign-extends them to 48 bits. It combines them with the accumulator feedback or the C operand under OPMODE control, and drives the slice's P output. It also flags signed overflow/underflow and provides an optional fixed-length accumulation counter with auto-restart. Sits directly after the multiplier stage in the DSP slice datapath.

Parameters:
PREG, 1, 1 = P and flags taken from the internal register (1-cycle latency); 0 = P and flags are the combinational next value.
USE_MULT, "multiply", "none" forces the product term to zero regardless of PP1/PP2.
ACC_LEN, 0, number of accumulate updates per accumulation run; 0 disables the counter, auto-restart and ACC_DONE.

Ports:
CLK  input  1  clock, rising edge.
RSTP  input  1  reset, asynchronous, active-high; clears all state.
CEP  input  1  clock enable for accumulator, flags and counter.
PP1  input  43  signed partial product 1.
PP2  input  43  signed partial product 2.
C  input  48  signed addend operand.
OPMODE  input  2  operation select; encodings below.
CARRYIN  input  1  carry-in added to the sum (modes 00/01/10 only).
P  output  48  signed result.
OVERFLOW  output  1  positive signed overflow on the last update.
UNDERFLOW  output  1  negative signed overflow on the last update.
ACC_DONE  output  1  one-cycle pulse when an accumulation run completes.

Behaviour:
- Reset: the port is named RSTP; one clock CLK; reset is asynchronous and active-high. While RSTP=1: ACC=0, P=0, OVERFLOW=0, UNDERFLOW=0, ACC_DONE=0, counter=0. Takes effect immediately, without a clock edge. Reset mid-run aborts it; no ACC_DONE is produced.
- PROD = sext48(PP1) + sext48(PP2); PROD = 0 when USE_MULT=="none".
- FB = ACC, except FB = 0 when the restart flag is set (see counter).
- OPMODE 00: NEXT = PROD + CARRYIN.
- OPMODE 01 (accumulate): NEXT = FB + PROD + CARRYIN.
- OPMODE 10: NEXT = C + PROD + CARRYIN.
- OPMODE 11 (hold): NEXT = ACC; flags are cleared.
- Arithmetic: compute a 49-bit signed sum S; NEXT = S[47:0], which wraps in two's complement with no saturation. OVF_n = (S[48]==0 && S[47]==1). UNF_n = (S[48]==1 && S[47]==0).
- On a rising CLK edge with CEP=1: ACC<=NEXT; flag registers <= OVF_n/UNF_n.
- With CEP=0: ACC, flags, counter and restart flag all hold, and ACC_DONE=0.
- PREG=1: P=ACC and flags are registered; latency from PP1/PP2 to P is 1 cycle.
- PREG=0: P=NEXT and flags are OVF_n/UNF_n, combinational. ACC still registers, so accumulation works.
- Counter (ACC_LEN>0): increments on each CEP=1 edge with OPMODE=01. When it reaches ACC_LEN it returns to 0, ACC_DONE pulses high for exactly 1 cycle after that edge, and the restart flag is set.
- Restart flag: forces FB=0 for the next OPMODE=01 update, then clears. Non-01 updates do not advance the counter. OPMODE 00 or 10 clears both the counter and the restart flag.
- ACC_LEN=0: ACC_DONE is tied 0 and FB is always ACC.
- Simultaneous events: RSTP dominates CEP and all other inputs.

Decomposition:
- Shared package (dsp_pkg) holds:
  - OPMODE encodings: OP_PROD=2'b00, OP_ACC=2'b01, OP_CADD=2'b10, OP_HOLD=2'b11.
  - Width constants: PP_W=43, P_W=48.
- One combinational sub-module, pp_combine: sign-extends and sums PP1/PP2 with the USE_MULT gating.
- The 49-bit adder, flag logic, counter and registers stay in pp_accumulate_alu.

Test Plan:
- PREG=1, OPMODE=00, PP1=100, PP2=-30, CARRYIN=0, CEP=1 -> P=70 one cycle later; OVERFLOW=UNDERFLOW=0. With PREG=0 -> P=70 in the same cycle.
- OPMODE=10, C=0x7FFF_FFFF_FFFF, PP1=1, PP2=0 -> P=0x8000_0000_0000, OVERFLOW=1. Then C=0x8000_0000_0000, PP1=-1 -> P=0x7FFF_FFFF_FFFF, UNDERFLOW=1.
- ACC_LEN=4, OPMODE=01, PP1=3, PP2=2 over 5 CEP cycles -> P=5,10,15,20,5. ACC_DONE=1 only in the cycle P=20. CARRYIN=1 on the first update -> first P=6.
- After 2 accumulate cycles (P=10), CEP=0 for 3 cycles -> P holds 10, no ACC_DONE. Then OPMODE=11 with CEP=1 -> P holds 10, flags 0.
- During an accumulation run at P=10, assert RSTP between clock edges -> P, flags and ACC_DONE go to 0 immediately. After deassertion, 4 accumulates of 5 -> ACC_DONE on the 4th.
- USE_MULT="none", OPMODE=10, C=1234, PP1=999, PP2=999 -> P=1234.
